// File: rtl/io_pkg.sv
// Shared definitions for the fabric I/O input conditioners: default
// parameter values, the debounce counter width helper and parameter
// range checks.
package io_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEB_CYCLES  = 4;

  // Counter must hold values up to DEB_CYCLES.
  function automatic int deb_cnt_w(input int deb_cycles);
    return $clog2(deb_cycles + 1);
  endfunction

endpackage

`ifndef IO_PKG_ASSERT_MACROS
`define IO_PKG_ASSERT_MACROS
// Parameter legality checks, evaluated on every clock so a misconfigured
// instance is reported as soon as simulation starts.
`define IO_ASSERT_SYNC_STAGES(clk_sig, value) \
  assert property (@(posedge clk_sig) (value) >= 2);
`define IO_ASSERT_DEB_CYCLES(clk_sig, value) \
  assert property (@(posedge clk_sig) (value) >= 1);
`endif

// File: rtl/gpio_in_filter_bit.sv
// Single-bit input conditioner: synchronizer chain, debounce counter,
// committed level register and registered rise/fall pulses.
//
// Update priority on every clock edge:
//   reset      -> everything cleared, no pulse
//   isolation  -> level/counter cleared, no pulse (sync chain keeps running)
//   bypass     -> level follows sync_q, counter held at 0
//   otherwise  -> level commits after DEB_CYCLES consecutive differing samples
module gpio_in_filter_bit
  import io_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic io_isol_n,
  input  logic pad_in,
  input  logic cfg_bypass,
  output logic data_out,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = deb_cnt_w(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync_q;
  logic [CNT_W-1:0]       cnt;

  assign sync_q = sync_chain[SYNC_STAGES-1];

  // Synchronizer: free-running, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], pad_in};
    end
  end

  // Debounce counter, committed level and edge pulses.
  always_ff @(posedge clk) begin
    if (reset || !io_isol_n) begin
      cnt      <= '0;
      data_out <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else if (cfg_bypass) begin
      cnt      <= '0;
      data_out <= sync_q;
      rise     <= sync_q & ~data_out;
      fall     <= ~sync_q & data_out;
    end else if (sync_q != data_out) begin
      if (cnt == CNT_LAST) begin
        cnt      <= '0;
        data_out <= sync_q;
        rise     <= sync_q;
        fall     <= ~sync_q;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        rise <= 1'b0;
        fall <= 1'b0;
      end
    end else begin
      cnt  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end
  end

  `IO_ASSERT_SYNC_STAGES(clk, SYNC_STAGES)
  `IO_ASSERT_DEB_CYCLES(clk, DEB_CYCLES)

endmodule

// File: rtl/gpio_in_filter.sv
// Input conditioner for the fabric I/O cell SOC_IN/GPIN nets: WIDTH
// independent synchronize+debounce lanes plus a combined change flag.
module gpio_in_filter
  import io_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_isol_n,
  input  logic [WIDTH-1:0] pad_in,
  input  logic [WIDTH-1:0] cfg_bypass,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  // One fully independent lane per input bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_in_filter_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
    ) u_bit (
      .clk        (clk),
      .reset      (reset),
      .io_isol_n  (io_isol_n),
      .pad_in     (pad_in[i]),
      .cfg_bypass (cfg_bypass[i]),
      .data_out   (data_out[i]),
      .rise       (rise[i]),
      .fall       (fall[i])
    );
  end

  // Flag any edge pulse on any lane (driven purely from registers).
  always_comb begin
    any_change = |(rise | fall);
  end

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed bench for gpio_in_filter with default parameters
// (WIDTH=8, SYNC_STAGES=2, DEB_CYCLES=4).
module tb_gpio_in_filter;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         io_isol_n;
  logic [W-1:0] pad_in;
  logic [W-1:0] cfg_bypass;
  logic [W-1:0] data_out;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         any_change;

  always #5 clk = ~clk;

  gpio_in_filter dut (
    .clk        (clk),
    .reset      (reset),
    .io_isol_n  (io_isol_n),
    .pad_in     (pad_in),
    .cfg_bypass (cfg_bypass),
    .data_out   (data_out),
    .rise       (rise),
    .fall       (fall),
    .any_change (any_change)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fails  = 0;
  logic [3*W-1:0] exp_q[$];   // {data_out, rise, fall} per table row

  typedef struct {
    logic [W-1:0] pad;
    logic [W-1:0] exp_data;
    logic [W-1:0] exp_rise;
    logic [W-1:0] exp_fall;
  } vec_t;

  vec_t vecs[$];

  task automatic check8(input string name, input logic [W-1:0] act,
                        input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the expected state after an edge.
  task automatic check_all(input string name, input logic [W-1:0] e_data,
                           input logic [W-1:0] e_rise, input logic [W-1:0] e_fall);
    check8({name, "/data_out"}, data_out, e_data);
    check8({name, "/rise"}, rise, e_rise);
    check8({name, "/fall"}, fall, e_fall);
    check8({name, "/any_change"}, {{(W-1){1'b0}}, any_change},
           {{(W-1){1'b0}}, |(e_rise | e_fall)});
    check8({name, "/rise_and_fall"}, rise & fall, '0);
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge and settle; inputs set after this are seen next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset      = 1'b1;
    io_isol_n  = 1'b1;
    pad_in     = '0;
    cfg_bypass = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic add_vec(input logic [W-1:0] pad, input logic [W-1:0] d,
                         input logic [W-1:0] r, input logic [W-1:0] f);
    vec_t v;
    v.pad = pad; v.exp_data = d; v.exp_rise = r; v.exp_fall = f;
    vecs.push_back(v);
  endtask

  task automatic add_n(input int n, input logic [W-1:0] pad, input logic [W-1:0] d);
    for (int i = 0; i < n; i++) add_vec(pad, d, '0, '0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [3*W-1:0] e;

    // Reset and idle: pad all high during reset.
    reset      = 1'b1;
    io_isol_n  = 1'b1;
    pad_in     = 8'hFF;
    cfg_bypass = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("reset_hold", '0, '0, '0);
    end
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_all("post_reset_wait", '0, '0, '0);
    end
    tick();
    check_all("post_reset_rise", 8'hFF, 8'hFF, '0);
    tick();
    check_all("post_reset_after", 8'hFF, '0, '0);

    // Table: debounced edge on bit 0, glitch rejection and a 4-cycle
    // pulse on bit 1. Row n's inputs are applied before edge n.
    add_n(5, 8'h01, 8'h00);
    add_vec(8'h01, 8'h01, 8'h01, 8'h00);
    add_n(1, 8'h01, 8'h01);
    add_n(5, 8'h00, 8'h01);
    add_vec(8'h00, 8'h00, 8'h00, 8'h01);
    add_n(1, 8'h00, 8'h00);
    add_n(3, 8'h02, 8'h00);           // 3-cycle glitch
    add_n(5, 8'h00, 8'h00);
    add_n(3, 8'h02, 8'h00);           // second glitch: counter must restart
    add_n(5, 8'h00, 8'h00);
    add_n(4, 8'h02, 8'h00);           // 4-cycle pulse
    add_n(1, 8'h00, 8'h00);
    add_vec(8'h00, 8'h02, 8'h02, 8'h00);
    add_n(3, 8'h00, 8'h02);
    add_vec(8'h00, 8'h00, 8'h00, 8'h02);
    add_n(2, 8'h00, 8'h00);

    reset_dut();
    foreach (vecs[i]) begin
      pad_in = vecs[i].pad;
      exp_q.push_back({vecs[i].exp_data, vecs[i].exp_rise, vecs[i].exp_fall});
      tick();
      e = exp_q.pop_front();
      check_all($sformatf("table[%0d]", i), e[3*W-1:2*W], e[2*W-1:W], e[W-1:0]);
    end

    // Bypass on bit 2: one-cycle pad pulse.
    reset_dut();
    cfg_bypass = 8'h04;
    pad_in     = 8'h04;
    tick();
    check_all("byp_k", '0, '0, '0);
    pad_in = '0;
    tick();
    check_all("byp_k1", '0, '0, '0);
    tick();
    check_all("byp_rise", 8'h04, 8'h04, '0);
    tick();
    check_all("byp_fall", '0, '0, 8'h04);
    tick();
    check_all("byp_idle", '0, '0, '0);
    cfg_bypass = '0;

    // Isolation with bit 3 committed high.
    reset_dut();
    pad_in = 8'h08;
    for (int i = 0; i < 5; i++) tick();
    tick();
    check_all("iso_pre", 8'h08, 8'h08, '0);
    io_isol_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all("iso_forced", '0, '0, '0);
    end
    io_isol_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("iso_release_wait", '0, '0, '0);
    end
    tick();
    check_all("iso_release_rise", 8'h08, 8'h08, '0);

    // Reset mid-debounce on bit 4 (counter at 2).
    reset_dut();
    pad_in = 8'h10;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all("mid_count", '0, '0, '0);
    end
    reset = 1'b1;
    tick();
    check_all("mid_reset", '0, '0, '0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all("after_reset_wait", '0, '0, '0);
    end
    tick();
    check_all("after_reset_rise", 8'h10, 8'h10, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/gpio_in_filter.md
Name: gpio_in_filter

Overview:
- Input conditioner between the SoC/pad-side input nets and the SOC_IN/GPIN inputs of the fabric I/O cells.
- Each bit runs through a synchronizer and then a per-bit debounce filter.
- Produces clean levels plus single-cycle rise/fall pulses for the fabric.
- Honours the active-low isolation signal, so nothing reaches the fabric while the I/O is isolated.

Parameters:
- WIDTH, 8: number of input bits.
- SYNC_STAGES, 2: synchronizer flops per bit. Legal range is 2 or more.
- DEB_CYCLES, 4: consecutive differing samples required before a new level is committed. Legal range is 1 or more.

Ports:
- clk  input  1  fabric clock.
- reset  input  1  synchronous, active-high reset.
- io_isol_n  input  1  active-low isolation. When 0, outputs are forced to 0.
- pad_in  input  WIDTH  asynchronous raw input levels from pads/SoC.
- cfg_bypass  input  WIDTH  quasi-static per-bit debounce bypass. When 1, that bit skips debounce.
- data_out  output  WIDTH  filtered level, registered.
- rise  output  WIDTH  1-cycle pulse when data_out bit goes 0->1, registered.
- fall  output  WIDTH  1-cycle pulse when data_out bit goes 1->0, registered.
- any_change  output  1  OR-reduction of (rise | fall), combinational from registers.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: all sync flops, counters, data_out, rise and fall are 0. any_change is therefore 0.
- Synchronizer:
  - Runs every cycle, including during isolation.
  - Is cleared only by reset.
  - sync_q is the last stage.
- Per-bit debounce counter:
  - Width is $clog2(DEB_CYCLES+1).
  - It advances only on an enabled edge: io_isol_n=1, cfg_bypass=0, and sync_q differs from data_out.
  - When sync_q equals data_out, the counter clears to 0 on the next edge. A glitch shorter than DEB_CYCLES samples never commits.
  - Commit happens on the DEB_CYCLES-th consecutive enabled edge: data_out is set to sync_q, the counter clears to 0, and the matching rise or fall pulse is 1 for exactly that cycle.
- Latency, pad change to data_out: a pad change set up before edge k is visible after edge k+SYNC_STAGES+DEB_CYCLES-1. With the defaults, data_out updates on the 6th edge counting k as the 1st.
- Bypass (cfg_bypass[i]=1, io_isol_n=1):
  - data_out[i] follows sync_q one edge later.
  - Edge pulses are generated on each change.
  - The counter is held at 0.
  - Latency is SYNC_STAGES edges.
- Bypass toggled mid-count: the counter clears, and filtering restarts from the current data_out.
- Isolation (io_isol_n=0), applied on the next edge:
  - data_out is forced to 0 and counters are cleared.
  - No rise or fall pulse is generated for the forced change, including a 1->0 forced change.
  - rise and fall are 0 throughout isolation.
- Release from isolation behaves as if from reset. If sync_q=1, rise fires on the DEB_CYCLES-th enabled edge (bypass: the first edge).
- rise[i] and fall[i] are never both 1 in the same cycle. Each bit is fully independent.
- Reset asserted mid-count or mid-pulse: everything is 0 on the next edge, and no pulse is emitted.

Decomposition:
- Shared package (io_pkg): function clog2-based DEB_CNT_W, localparam defaults, and the legal-range assertion macros for SYNC_STAGES and DEB_CYCLES.
- Sub-module gpio_in_filter_bit: one sync chain, counter, level register and pulse logic for a single bit.
- Top level: generate-loop of WIDTH instances plus the any_change OR.

Test Plan:
- Reset and idle:
  - Stimulus: reset=1 for 3 cycles with pad_in=8'hFF, io_isol_n=1; then release reset.
  - Required: data_out=0, rise=0, fall=0 and any_change=0 during reset. After release, rise=8'hFF pulses exactly once, on the 6th edge after the release edge.
- Debounced edge:
  - Stimulus: defaults. pad_in[0] goes 0->1 before edge k and is held.
  - Required: data_out[0]=1 after edge k+5. rise[0]=1 and any_change=1 for that cycle only. No fall.
  - Stimulus: then pad_in[0] goes 1->0 and is held.
  - Required: a fall[0] pulse 6 edges later.
- Glitch rejection:
  - Stimulus: pad_in[1] high for 3 cycles, then low.
  - Required: data_out[1] stays 0, no pulses, counter returns to 0.
  - Stimulus: repeat with a 4-cycle pulse.
  - Required: data_out[1] goes 1 for one sample window. Check the rise then fall pulses.
- Bypass:
  - Stimulus: cfg_bypass=8'h04, 1-cycle pulse on pad_in[2].
  - Required: data_out[2] is high for exactly 1 cycle, starting 2 edges after the pulse. rise[2] and fall[2] pulse in consecutive cycles.
- Isolation mid-operation:
  - Stimulus: data_out[3]=1, then io_isol_n goes to 0.
  - Required: data_out[3]=0 next cycle, fall[3] never asserts.
  - Stimulus: raise io_isol_n at edge r with pad still high.
  - Required: rise[3] at edge r+3.
- Reset mid-debounce:
  - Stimulus: assert reset for 1 cycle at count 2 of a pending 0->1.
  - Required: no pulse, data_out=0. A full 6-edge latency is needed again afterwards.
